ahb_apb_bridge: RTL and testbench



---
 rtl/ahb_pkg.sv | 29 ++
 rtl/ahb_apb_timeout.sv | 30 +++
 rtl/ahb_apb_bridge.sv | 195 +++++++++++++++++++
 tb/tb_ahb_apb_bridge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB/APB bridge definitions: FSM states, HTRANS/HSIZE/HRESP encodings
// and a helper that flags an active (NONSEQ/SEQ) transfer.
package ahb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_apb_timeout.sv
// ACCESS-phase watchdog counter: synchronous clear, count enable and a
// terminal-count flag raised when the count reaches TIMEOUT_CYCLES-1.
module ahb_apb_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_terminal
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] r_count;

  // Clear has priority so every new APB transfer starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_terminal = (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB3 bridge, one transfer in flight.
// Optional ACCESS-phase timeout: define AHB_APB_BRIDGE_TIMEOUT_EN.
//
// Handshake: an AHB transfer is accepted when HSEL & HTRANS(NONSEQ/SEQ) &
// HREADY is seen while the bridge can accept (IDLE/DONE/ERR2); the data phase
// is held with HREADYOUT=0 until the APB completer returns PREADY=1 in ACCESS,
// at which point PSLVERR is sampled. No other signal completes a transfer.
module ahb_apb_bridge
  import ahb_pkg::*;
#(
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int PAW            = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  input  logic           HSEL,
  input  logic [AW-1:0]  HADDR,
  input  logic           HWRITE,
  input  logic [2:0]     HSIZE,
  input  logic [1:0]     HTRANS,
  input  logic           HREADY,
  input  logic [DW-1:0]  HWDATA,
  output logic           HREADYOUT,
  output logic [DW-1:0]  HRDATA,
  output logic           HRESP,
  output logic           PSEL,
  output logic           PENABLE,
  output logic           PWRITE,
  output logic [PAW-1:0] PADDR,
  output logic [DW-1:0]  PWDATA,
  input  logic [DW-1:0]  PRDATA,
  input  logic           PREADY,
  input  logic           PSLVERR,
  output state_t         o_dbg_state
);

  localparam logic [31:0] LP_TIMEOUT = TIMEOUT_CYCLES;

  state_t         r_state;
  state_t         w_next;
  logic           w_can_accept;
  logic           w_capture;
  logic           w_size_ok;
  logic           w_timeout;
  logic           w_rd_done;
  logic           w_psel;
  logic           w_penable;
  logic           w_hreadyout;
  logic           w_hresp;
  logic           r_psel;
  logic           r_penable;
  logic           r_hreadyout;
  logic           r_hresp;
  logic           r_pwrite;
  logic [PAW-1:0] r_paddr;
  logic [DW-1:0]  r_hrdata;
  logic           w_unused;

  // Upper address bits select the bridge in the fabric decoder, not here.
  assign w_unused = ^{HADDR[AW-1:PAW], LP_TIMEOUT[0]};

  assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                        (r_state == ST_ERR2);
  assign w_capture    = w_can_accept & HSEL & htrans_active(HTRANS) & HREADY;
  // Sub-word reads return the full word; sub-word writes cannot be expressed
  // on APB3 without strobes, so they are rejected.
  assign w_size_ok    = !HWRITE || (HSIZE == HSIZE_WORD);
  assign w_rd_done    = (r_state == ST_ACCESS) & PREADY & ~PSLVERR & ~r_pwrite;

`ifdef AHB_APB_BRIDGE_TIMEOUT_EN
  logic w_terminal;

  ahb_apb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .i_clear    (r_state == ST_SETUP),
    .i_count_en ((r_state == ST_ACCESS) && !PREADY),
    .o_terminal (w_terminal)
  );

  assign w_timeout = w_terminal;
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state; PREADY in the terminal-count cycle still completes normally.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (w_capture) begin
          w_next = w_size_ok ? ST_SETUP : ST_ERR1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          w_next = PSLVERR ? ST_ERR1 : ST_DONE;
        end else if (w_timeout) begin
          w_next = ST_ERR1;
        end
      end
      ST_ERR1:   w_next = ST_ERR2;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Output values for the state being entered, registered below.
  always_comb begin
    w_psel      = 1'b0;
    w_penable   = 1'b0;
    w_hreadyout = 1'b1;
    w_hresp     = HRESP_OKAY;
    case (w_next)
      ST_SETUP: begin
        w_psel      = 1'b1;
        w_hreadyout = 1'b0;
      end
      ST_ACCESS: begin
        w_psel      = 1'b1;
        w_penable   = 1'b1;
        w_hreadyout = 1'b0;
      end
      ST_ERR1: begin
        w_hreadyout = 1'b0;
        w_hresp     = HRESP_ERROR;
      end
      ST_ERR2: begin
        w_hresp     = HRESP_ERROR;
      end
      default: ;
    endcase
  end

  // Registered AHB/APB control outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
    end else begin
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_hreadyout <= w_hreadyout;
      r_hresp     <= w_hresp;
    end
  end

  // Address-phase capture of APB address and direction.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
    end else if (w_capture && w_size_ok) begin
      r_paddr  <= HADDR[PAW-1:0];
      r_pwrite <= HWRITE;
    end
  end

  // Read data holds its last value; only a successful read updates it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hrdata <= '0;
    end else if (w_rd_done) begin
      r_hrdata <= PRDATA;
    end
  end

  assign HREADYOUT   = r_hreadyout;
  assign HRESP       = r_hresp;
  assign HRDATA      = r_hrdata;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = HWDATA;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge with a small APB completer model and
// AHB-response / APB-transfer scoreboards.
module tb_ahb_apb_bridge;
  import ahb_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int PAW = 16;

  logic           HCLK;
  logic           HRESETn;
  logic           HSEL;
  logic [AW-1:0]  HADDR;
  logic           HWRITE;
  logic [2:0]     HSIZE;
  logic [1:0]     HTRANS;
  logic           HREADY;
  logic [DW-1:0]  HWDATA;
  logic           HREADYOUT;
  logic [DW-1:0]  HRDATA;
  logic           HRESP;
  logic           PSEL;
  logic           PENABLE;
  logic           PWRITE;
  logic [PAW-1:0] PADDR;
  logic [DW-1:0]  PWDATA;
  logic [DW-1:0]  PRDATA;
  logic           PREADY;
  logic           PSLVERR;
  state_t         dbg_state;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // {hresp, hrdata} expected at the end of each AHB data phase
  logic [32:0] exp_q[$];
  // {pwrite, paddr, pwdata} expected at each APB completion
  logic [48:0] apb_q[$];

  int          cfg_waits = 0;
  logic [31:0] cfg_rdata = '0;
  logic        cfg_err   = 1'b0;
  logic [31:0] last_rd   = '0;

  // Single slave on the bus: bus-level HREADY is this slave's HREADYOUT.
  assign HREADY = HREADYOUT;

  ahb_apb_bridge #(
    .DW(DW), .AW(AW), .PAW(PAW), .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .o_dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // APB completer: inserts cfg_waits wait states in ACCESS, then responds.
  initial begin
    int wcnt;
    wcnt    = 0;
    PREADY  = 1'b0;
    PRDATA  = '0;
    PSLVERR = 1'b0;
    forever begin
      @(posedge HCLK);
      #1;
      if (PSEL && PENABLE) begin
        if (wcnt >= cfg_waits) begin
          PREADY  = 1'b1;
          PRDATA  = cfg_rdata;
          PSLVERR = cfg_err;
        end else begin
          PREADY = 1'b0;
          wcnt++;
        end
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        wcnt    = 0;
      end
    end
  end

  // APB monitor: each completed ACCESS is checked against the expected queue.
  initial begin
    logic [48:0] e;
    forever begin
      @(negedge HCLK);
      if (HRESETn && PSEL && PENABLE && PREADY) begin
        if (apb_q.size() == 0) begin
          chk("apb_unexpected", 64'd1, 64'd0);
        end else begin
          e = apb_q.pop_front();
          chk("apb_wr_addr", {47'd0, PWRITE, PADDR}, {47'd0, e[48:32]});
          if (e[48]) chk("apb_wdata", {32'd0, PWDATA}, {32'd0, e[31:0]});
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  // One AHB transfer: address phase now, data phase until HREADYOUT=1.
  // Returns at the negedge of the final data-phase cycle so a following
  // call can place its address phase in that same cycle.
  task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                      input logic [2:0] size, input logic [31:0] wdata,
                      input logic exp_err, input logic has_apb, input logic push_apb,
                      input int exp_low, input int exp_psel, input int exp_pen);
    int          low, np, ne, bad_pw, n;
    logic        done, first_psel, last_resp;
    logic [32:0] e;
    if (!wr && !exp_err) last_rd = cfg_rdata;
    exp_q.push_back({exp_err, last_rd});
    if (push_apb) apb_q.push_back({wr, addr[15:0], wdata});
    HSEL   = 1'b1;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = size;
    HTRANS = HTRANS_NONSEQ;
    @(posedge HCLK);
    #1;
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    HWDATA = wdata;
    low = 0; np = 0; ne = 0; bad_pw = 0; n = 0;
    done = 1'b0; first_psel = 1'b0; last_resp = 1'b0;
    while (!done && n < 200) begin
      @(negedge HCLK);
      if (n == 0) first_psel = PSEL;
      if (HREADYOUT) begin
        done = 1'b1;
      end else begin
        low++;
        if (PSEL) np++;
        if (PENABLE) ne++;
        if (wr && PSEL && (PWDATA !== wdata)) bad_pw++;
        last_resp = HRESP;
        n++;
        @(posedge HCLK);
        #1;
      end
    end
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_setup_next"}, {63'd0, first_psel}, {63'd0, has_apb});
    chk({tag, "_wait_cycles"}, 64'(low), 64'(exp_low));
    chk({tag, "_psel_cycles"}, 64'(np), 64'(exp_psel));
    chk({tag, "_penable_cycles"}, 64'(ne), 64'(exp_pen));
    if (wr) chk({tag, "_pwdata_stable"}, 64'(bad_pw), 64'd0);
    if (exp_err) chk({tag, "_err_first"}, {63'd0, last_resp}, 64'd1);
    e = exp_q.pop_front();
    chk({tag, "_resp"}, {31'd0, HRESP, HRDATA}, {31'd0, e});
  endtask

  // Directed sequence.
  initial begin
    logic seen;
    HRESETn = 1'b0;
    HSEL    = 1'b0;
    HADDR   = '0;
    HWRITE  = 1'b0;
    HSIZE   = HSIZE_WORD;
    HTRANS  = HTRANS_IDLE;
    HWDATA  = '0;
    idle(3);
    chk("rst_hreadyout", {63'd0, HREADYOUT}, 64'd1);
    chk("rst_hresp", {63'd0, HRESP}, 64'd0);
    chk("rst_hrdata", {32'd0, HRDATA}, 64'd0);
    chk("rst_psel_penable", {62'd0, PSEL, PENABLE}, 64'd0);
    chk("rst_pwrite_paddr", {47'd0, PWRITE, PADDR}, 64'd0);
    chk("rst_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    HRESETn = 1'b1;
    idle(2);

    // Zero-wait read
    cfg_waits = 0; cfg_rdata = 32'hDEAD_BEEF; cfg_err = 1'b0;
    xfer("rd0", 32'h4000_0010, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 1'b1, 1'b1, 2, 2, 1);
    idle(2);

    // Write with three wait states
    cfg_waits = 3;
    xfer("wr_wait3", 32'h4000_0004, 1'b1, HSIZE_WORD, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 5, 5, 4);
    idle(2);

    // Slave error on a read: HRDATA must keep DEAD_BEEF
    cfg_waits = 0; cfg_rdata = 32'h0BAD_0BAD; cfg_err = 1'b1;
    xfer("rd_slverr", 32'h4000_0018, 1'b0, HSIZE_WORD, 32'h0, 1'b1, 1'b1, 1'b1, 3, 2, 1);
    cfg_err = 1'b0;
    idle(2);

    // Byte write rejected without touching APB
    xfer("wr_byte", 32'h4000_0001, 1'b1, 3'b000, 32'h0000_00AA, 1'b1, 1'b0, 1'b0, 1, 0, 0);
    idle(2);

    // Halfword read is allowed and returns the full word
    cfg_rdata = 32'hCAFE_F00D;
    xfer("rd_half", 32'h4000_0022, 1'b0, 3'b001, 32'h0, 1'b0, 1'b1, 1'b1, 2, 2, 1);
    idle(2);

    // Back-to-back: write, then read captured during the write's DONE cycle
    cfg_waits = 0; cfg_rdata = 32'h5555_AAAA;
    xfer("b2b_wr", 32'h4000_0030, 1'b1, HSIZE_WORD, 32'h8765_4321, 1'b0, 1'b1, 1'b1, 2, 2, 1);
    xfer("b2b_rd", 32'h4000_0034, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 1'b1, 1'b1, 2, 2, 1);
    idle(2);

    // HTRANS IDLE/BUSY while selected: zero-wait OKAY, no state change
    HSEL = 1'b1; HTRANS = HTRANS_IDLE; HADDR = 32'h4000_0040; HWRITE = 1'b1;
    @(negedge HCLK);
    @(posedge HCLK); #1;
    HTRANS = HTRANS_BUSY;
    @(negedge HCLK);
    chk("idle_trans_ready_resp", {62'd0, HREADYOUT, HRESP}, 64'd2);
    chk("idle_trans_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    chk("busy_trans_ready_resp", {62'd0, HREADYOUT, HRESP}, 64'd2);
    chk("busy_trans_psel", {63'd0, PSEL}, 64'd0);
    idle(2);

`ifdef AHB_APB_BRIDGE_TIMEOUT_EN
    // Completer stuck: abort after 8 ACCESS cycles with an ERROR response
    cfg_waits = 1000;
    xfer("timeout", 32'h4000_0050, 1'b1, HSIZE_WORD, 32'h0F0F_0F0F, 1'b1, 1'b1, 1'b0, 10, 9, 8);
`else
    // Without the timeout a long wait completes normally
    cfg_waits = 20;
    xfer("long_wait", 32'h4000_0050, 1'b1, HSIZE_WORD, 32'h0F0F_0F0F, 1'b0, 1'b1, 1'b1, 22, 22, 21);
`endif
    idle(2);

    // Reset pulse in the middle of ACCESS
    cfg_waits = 50;
    HSEL = 1'b1; HADDR = 32'h4000_0060; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
    HTRANS = HTRANS_NONSEQ;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 32'h7777_7777;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge HCLK);
      if (PENABLE) seen = 1'b1;
    end
    chk("rst_mid_reached_access", {63'd0, seen}, 64'd1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("rst_mid_psel_penable", {62'd0, PSEL, PENABLE}, 64'd0);
    chk("rst_mid_ready_resp", {62'd0, HREADYOUT, HRESP}, 64'd2);
    chk("rst_mid_hrdata", {32'd0, HRDATA}, 64'd0);
    chk("rst_mid_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    last_rd = '0;
    #3;
    HRESETn = 1'b1;
    idle(2);

    // Recovery after reset
    cfg_waits = 1; cfg_rdata = 32'hA5A5_0001;
    xfer("rd_after_rst", 32'h4000_0070, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 1'b1, 1'b1, 3, 3, 2);
    idle(3);

    chk("apb_q_drained", 64'(apb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
